// File: rtl/soc_evt_arbiter.sv
// Merges events from NB_SRC sources into one FIFO write port.
// Each source has a one-entry holding register, drained round-robin into a registered output stage.
module soc_evt_arbiter #(
    parameter int NB_SRC    = 4,
    parameter int ID_WIDTH  = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NB_SRC-1:0]                 src_valid_i,
    input  logic [NB_SRC-1:0][ID_WIDTH-1:0]   src_id_i,
    output logic                              fifo_data_valid_o,
    output logic [ID_WIDTH-1:0]               fifo_data_o,
    input  logic                              fifo_fulln_i,
    output logic [NB_SRC-1:0]                 pending_o,
    output logic [CNT_WIDTH-1:0]              drop_cnt_o,
    input  logic                              clr_drop_i,
    output logic                              busy_o
);

    localparam int PTR_W = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;
    localparam int N_W   = $clog2(NB_SRC + 1);
    localparam int SUM_W = ((CNT_WIDTH > N_W) ? CNT_WIDTH : N_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_WIDTH{1'b1}});

    logic [NB_SRC-1:0]                pend;
    logic [NB_SRC-1:0]                pend_nxt;
    logic [NB_SRC-1:0][ID_WIDTH-1:0]  hold;
    logic [PTR_W-1:0]                 rr_ptr;

    logic                             free;
    logic                             grant_vld;
    logic [PTR_W-1:0]                 grant_idx;
    logic [NB_SRC-1:0]                grant_oh;
    logic [NB_SRC-1:0]                capture;
    logic [NB_SRC-1:0]                drop;
    logic [N_W-1:0]                   n_drop;
    logic [SUM_W-1:0]                 drop_sum;
    logic [CNT_WIDTH-1:0]             drop_cnt_nxt;

    // An empty output register may load even when the FIFO reports full.
    assign free = ~fifo_data_valid_o | fifo_fulln_i;

    always_comb begin
        int               idx;
        logic [PTR_W-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        cand      = '0;
        if (free) begin
            for (int k = 0; k < NB_SRC; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NB_SRC) begin
                    idx = idx - NB_SRC;
                end
                cand = PTR_W'(idx);
                if (!grant_vld && pend[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    // A granted source can accept a new event in the same cycle it drains.
    always_comb begin
        grant_oh = '0;
        capture  = '0;
        drop     = '0;
        pend_nxt = pend;
        n_drop   = '0;
        for (int i = 0; i < NB_SRC; i++) begin
            grant_oh[i] = grant_vld && (grant_idx == PTR_W'(i));
            capture[i]  = src_valid_i[i] && (!pend[i] || grant_oh[i]);
            drop[i]     = src_valid_i[i] && pend[i] && !grant_oh[i];
            if (capture[i]) begin
                pend_nxt[i] = 1'b1;
            end else if (grant_oh[i]) begin
                pend_nxt[i] = 1'b0;
            end
            n_drop = n_drop + N_W'(drop[i]);
        end
    end

    always_comb begin
        drop_sum     = SUM_W'(drop_cnt_o) + SUM_W'(n_drop);
        drop_cnt_nxt = drop_cnt_o;
        if (clr_drop_i) begin
            drop_cnt_nxt = '0;
        end else if (drop_sum > CNT_MAX) begin
            drop_cnt_nxt = {CNT_WIDTH{1'b1}};
        end else begin
            drop_cnt_nxt = CNT_WIDTH'(drop_sum);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend <= '0;
            hold <= '0;
        end else begin
            pend <= pend_nxt;
            for (int i = 0; i < NB_SRC; i++) begin
                if (capture[i]) begin
                    hold[i] <= src_id_i[i];
                end
            end
        end
    end

    // Output registers freeze while the FIFO stalls a valid event.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fifo_data_valid_o <= 1'b0;
            fifo_data_o       <= '0;
            rr_ptr            <= '0;
        end else if (free) begin
            fifo_data_valid_o <= grant_vld;
            if (grant_vld) begin
                fifo_data_o <= hold[grant_idx];
                if (int'(grant_idx) == NB_SRC - 1) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant_idx + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_o <= '0;
        end else begin
            drop_cnt_o <= drop_cnt_nxt;
        end
    end

    assign pending_o = pend;
    assign busy_o    = (|pend) | fifo_data_valid_o;

endmodule

// File: tb/tb_soc_evt_arbiter.sv
// Directed bench for soc_evt_arbiter; a scoreboard queue holds the expected output IDs in order.
module tb_soc_evt_arbiter;

    localparam int NB  = 4;
    localparam int IDW = 8;
    localparam int CW  = 4;

    logic                      clk;
    logic                      rst;
    logic [NB-1:0]             src_valid;
    logic [NB-1:0][IDW-1:0]    src_id;
    logic                      fifo_data_valid;
    logic [IDW-1:0]            fifo_data;
    logic                      fifo_fulln;
    logic [NB-1:0]             pending;
    logic [CW-1:0]             drop_cnt;
    logic                      clr_drop;
    logic                      busy;

    int checks = 0;
    int errors = 0;
    logic [IDW-1:0] exp_q[$];

    soc_evt_arbiter #(.NB_SRC(NB), .ID_WIDTH(IDW), .CNT_WIDTH(CW)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .src_valid_i       (src_valid),
        .src_id_i          (src_id),
        .fifo_data_valid_o (fifo_data_valid),
        .fifo_data_o       (fifo_data),
        .fifo_fulln_i      (fifo_fulln),
        .pending_o         (pending),
        .drop_cnt_o        (drop_cnt),
        .clr_drop_i        (clr_drop),
        .busy_o            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NB-1:0] v, input logic [NB-1:0][IDW-1:0] ids);
        src_valid = v;
        src_id    = ids;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int budget;
        budget = 50;
        while (exp_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        tick();
        tick();
    endtask

    // Transfers are sampled mid-cycle; each accepted event must match the queue head.
    always @(negedge clk) begin
        if (!rst && fifo_data_valid === 1'b1 && fifo_fulln === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_out", 32'(fifo_data), 32'hFFFF_FFFF);
            end else begin
                checkOutput("out_id", 32'(fifo_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst        = 1'b1;
        fifo_fulln = 1'b1;
        clr_drop   = 1'b0;
        applyStimulus('0, '0);
        tick();
        tick();
        checkOutput("rst_pending", 32'(pending), 32'd0);
        checkOutput("rst_valid",   32'(fifo_data_valid), 32'd0);
        checkOutput("rst_data",    32'(fifo_data), 32'd0);
        checkOutput("rst_drop",    32'(drop_cnt), 32'd0);
        checkOutput("rst_busy",    32'(busy), 32'd0);
        rst = 1'b0;

        // Single event latency
        applyStimulus(4'b0100, {8'h00, 8'h2A, 8'h00, 8'h00});
        exp_q.push_back(8'h2A);
        tick();
        applyStimulus('0, '0);
        checkOutput("single_pend", 32'(pending), 32'b0100);
        checkOutput("single_v1",   32'(fifo_data_valid), 32'd0);
        checkOutput("single_busy", 32'(busy), 32'd1);
        tick();
        checkOutput("single_v2",   32'(fifo_data_valid), 32'd1);
        checkOutput("single_data", 32'(fifo_data), 32'h2A);
        checkOutput("single_pend2", 32'(pending), 32'd0);
        tick();
        checkOutput("single_v3",   32'(fifo_data_valid), 32'd0);
        checkOutput("single_drop", 32'(drop_cnt), 32'd0);
        drain();

        // Round robin from a freshly reset pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(4'b1111, {8'h13, 8'h12, 8'h11, 8'h10});
        exp_q.push_back(8'h10); exp_q.push_back(8'h11);
        exp_q.push_back(8'h12); exp_q.push_back(8'h13);
        tick();
        applyStimulus('0, '0);
        checkOutput("rr_pend_all", 32'(pending), 32'b1111);
        drain();
        applyStimulus(4'b1111, {8'h23, 8'h22, 8'h21, 8'h20});
        exp_q.push_back(8'h20); exp_q.push_back(8'h21);
        exp_q.push_back(8'h22); exp_q.push_back(8'h23);
        tick();
        applyStimulus('0, '0);
        drain();
        applyStimulus(4'b0010, {8'h00, 8'h00, 8'h31, 8'h00});
        exp_q.push_back(8'h31);
        tick();
        applyStimulus('0, '0);
        drain();
        applyStimulus(4'b1111, {8'h13, 8'h12, 8'h11, 8'h10});
        exp_q.push_back(8'h12); exp_q.push_back(8'h13);
        exp_q.push_back(8'h10); exp_q.push_back(8'h11);
        tick();
        applyStimulus('0, '0);
        drain();

        // Backpressure: empty output loads despite full FIFO, then stalls
        applyStimulus(4'b0001, {8'h00, 8'h00, 8'h00, 8'h05});
        tick();
        applyStimulus(4'b0001, {8'h00, 8'h00, 8'h00, 8'h06});
        fifo_fulln = 1'b0;
        exp_q.push_back(8'h05); exp_q.push_back(8'h06);
        tick();
        applyStimulus('0, '0);
        checkOutput("bp_valid", 32'(fifo_data_valid), 32'd1);
        checkOutput("bp_pend",  32'(pending), 32'b0001);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) applyStimulus(4'b0001, {8'h00, 8'h00, 8'h00, 8'h07});
            tick();
            applyStimulus('0, '0);
            checkOutput("bp_stall_data", 32'(fifo_data), 32'h05);
        end
        checkOutput("bp_stall_valid", 32'(fifo_data_valid), 32'd1);
        checkOutput("bp_drop", 32'(drop_cnt), 32'd1);
        fifo_fulln = 1'b1;
        drain();

        // Grant and refill in the same cycle
        applyStimulus(4'b0010, {8'h00, 8'h00, 8'h40, 8'h00});
        exp_q.push_back(8'h40); exp_q.push_back(8'h41);
        tick();
        applyStimulus(4'b0010, {8'h00, 8'h00, 8'h41, 8'h00});
        tick();
        applyStimulus('0, '0);
        checkOutput("refill_data", 32'(fifo_data), 32'h40);
        checkOutput("refill_pend", 32'(pending), 32'b0010);
        tick();
        checkOutput("refill_data2", 32'(fifo_data), 32'h41);
        checkOutput("refill_pend2", 32'(pending), 32'd0);
        checkOutput("refill_drop",  32'(drop_cnt), 32'd1);
        drain();

        // Drop counter saturation and clear priority
        clr_drop = 1'b1;
        tick();
        clr_drop = 1'b0;
        checkOutput("clr_drop", 32'(drop_cnt), 32'd0);
        fifo_fulln = 1'b0;
        applyStimulus(4'b0001, {8'h00, 8'h00, 8'h00, 8'h70});
        tick();
        applyStimulus(4'b1111, {8'h83, 8'h82, 8'h81, 8'h80});
        tick();
        checkOutput("sat_out",  32'(fifo_data), 32'h70);
        checkOutput("sat_pend", 32'(pending), 32'b1111);
        checkOutput("sat_drop0", 32'(drop_cnt), 32'd0);
        exp_q.push_back(8'h70); exp_q.push_back(8'h81); exp_q.push_back(8'h82);
        exp_q.push_back(8'h83); exp_q.push_back(8'h80);
        applyStimulus(4'b0011, {8'h00, 8'h00, 8'hEE, 8'hEE});
        for (int k = 1; k <= 10; k++) begin
            tick();
            checkOutput("sat_drop", 32'(drop_cnt), (2 * k > 15) ? 32'd15 : 32'(2 * k));
        end
        clr_drop = 1'b1;
        tick();
        clr_drop = 1'b0;
        applyStimulus('0, '0);
        checkOutput("clr_with_drops", 32'(drop_cnt), 32'd0);
        checkOutput("sat_hold_out", 32'(fifo_data), 32'h70);
        fifo_fulln = 1'b1;
        drain();

        // Reset mid-stream discards held and in-flight events
        fifo_fulln = 1'b0;
        applyStimulus(4'b0001, {8'h00, 8'h00, 8'h00, 8'h90});
        tick();
        applyStimulus(4'b1110, {8'h93, 8'h92, 8'h91, 8'h00});
        tick();
        checkOutput("mid_pend",  32'(pending), 32'b1110);
        checkOutput("mid_valid", 32'(fifo_data_valid), 32'd1);
        applyStimulus(4'b0010, {8'h00, 8'h00, 8'h99, 8'h00});
        tick();
        applyStimulus('0, '0);
        checkOutput("mid_drop", 32'(drop_cnt), 32'd1);
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_pend",  32'(pending), 32'd0);
        checkOutput("mid_rst_valid", 32'(fifo_data_valid), 32'd0);
        checkOutput("mid_rst_drop",  32'(drop_cnt), 32'd0);
        checkOutput("mid_rst_busy",  32'(busy), 32'd0);
        rst = 1'b0;
        fifo_fulln = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        checkOutput("final_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_evt_arbiter.md
Name: soc_evt_arbiter

Overview:
Merges event IDs from NB_SRC independent SoC event sources into the single write port of the SoC peripheral event FIFO. Each source has a one-entry holding register, and a round-robin arbiter drains these into a registered output stage. The output stage obeys the FIFO's full-not handshake. Events that arrive while a source's holding register is occupied and not draining are dropped and counted.

Parameters:
NB_SRC, 4, number of event sources (>=2)
ID_WIDTH, 8, event ID width; must match FIFO ID_WIDTH
CNT_WIDTH, 16, width of saturating drop counter

Ports:
clk_i  in  1  clock; all logic on the rising edge
rst_i  in  1  reset, synchronous, active-high
src_valid_i  in  NB_SRC  per-source event strobe; one event per cycle per asserted bit; no backpressure
src_id_i  in  NB_SRC x ID_WIDTH  per-source event ID, sampled when the matching src_valid_i bit is high
fifo_data_valid_o  out  1  output event valid (registered)
fifo_data_o  out  ID_WIDTH  output event ID (registered)
fifo_fulln_i  in  1  FIFO has space; transfer occurs when fifo_data_valid_o & fifo_fulln_i
pending_o  out  NB_SRC  holding-register occupancy per source
drop_cnt_o  out  CNT_WIDTH  saturating count of dropped events
clr_drop_i  in  1  clears drop_cnt_o
busy_o  out  1  OR of pending_o and fifo_data_valid_o

Behaviour:
- Reset (rst_i=1 at clock edge): pend=0, hold data=0, fifo_data_valid_o=0, fifo_data_o=0, rr pointer=0, drop_cnt_o=0. Reset mid-operation discards all held and in-flight events, and they are not counted as drops.
- Output stage "free" = ~fifo_data_valid_o | fifo_fulln_i.
- Arbitration is combinational on the current pend vector. When free and pend != 0, grant exactly one source g. The search starts at rr_ptr and wraps modulo NB_SRC. When free is 0, there is no grant.
- On a grant: fifo_data_o <= hold[g], fifo_data_valid_o <= 1, pend[g] cleared (unless refilled, see below), rr_ptr <= (g+1) mod NB_SRC.
- Free with no grant: fifo_data_valid_o <= 0. Not free: output registers hold their values, so fifo_data_o is stable while fifo_data_valid_o=1 and fifo_fulln_i=0.
- rr_ptr changes only on a grant.
- Capture for each source i when src_valid_i[i]=1:
  - If pend[i]=0, or i is granted this cycle: hold[i] <= src_id_i[i], pend[i] <= 1. Grant and refill in the same cycle leaves pend[i]=1 with the new ID.
  - Otherwise the event is dropped.
- Drops: n = number of sources dropping this cycle (0..NB_SRC).
  - drop_cnt_o <= min(drop_cnt_o + n, 2^CNT_WIDTH-1).
  - clr_drop_i=1 has priority: drop_cnt_o <= 0, and drops in that same cycle are not counted.
- Latency: a source event at edge t is held at t+1. It appears on fifo_data_valid_o at t+2 at the earliest, if uncontended and the output is free.
- Throughput: one event per cycle while fifo_fulln_i=1.
- Fairness: with all sources continuously pending, each is granted once every NB_SRC grants.
- Full FIFO (fifo_fulln_i=0, output valid): no grants. Held events wait, and further events to occupied sources are dropped.
- Ordering: per-source order is preserved. No cross-source ordering is guaranteed.
- An empty output with fifo_fulln_i=0 is still free. The FIFO only gates acceptance, not loading of an empty output register.

Test Plan:
- Reset, then a single event: src_valid_i=4'b0100, src_id_i[2]=8'h2A at cycle 0, fifo_fulln_i=1 -> pending_o[2]=1 at cycle 1; fifo_data_valid_o=1, fifo_data_o=8'h2A at cycle 2; valid=0 at cycle 3; drop_cnt_o=0.
- Round-robin: all four sources fire once simultaneously with IDs 10,11,12,13, rr_ptr=0 -> output sequence 10,11,12,13 on consecutive cycles. A second burst of 20..23 issued after rr_ptr=0 again yields 20,21,22,23. With rr_ptr preset to 2 via a prior grant of source 1, the order is 12,13,10,11.
- Backpressure: fifo_fulln_i=0 while the output holds 8'h05 and source 0 holds 8'h06 -> fifo_data_o stays 8'h05 for 10 cycles. A new src0 event during stall -> drop_cnt_o increments to 1. Release -> 8'h05, then 8'h06.
- Grant plus refill: source 1 is pending with 8'h40 and granted in the same cycle src_valid_i[1]=1 with 8'h41 -> output 8'h40, pending_o[1] stays 1, next output 8'h41, no drop.
- Saturation and clear: CNT_WIDTH=4, force 20 drops -> drop_cnt_o=15. clr_drop_i asserted in a cycle with 2 drops -> drop_cnt_o=0.
- Reset mid-stream: rst_i=1 for one cycle with 3 pending and output valid -> next cycle pending_o=0, fifo_data_valid_o=0, drop_cnt_o=0, busy_o=0.
